debug_trace: RTL and testbench
==============================

# debug_trace

Parametrised instruction trace recorder for the simplecore debug path. It captures a circular history of retired instructions (PC, instruction class, ALU control) and freezes after a programmable trigger plus a post-trigger window. It then drains the history oldest-first through a valid/ready-style read port, decoding each entry to fixed-width ASCII mnemonics for waveform and console display. It sits beside the core's writeback stage and observes only; it never stalls the core.

## Interface
- DEPTH, 16, trace entries; power of two, 4..256.
- PC_W, 32, captured PC width.
- POST_TRIG, 4, entries captured after the trigger entry; 0..DEPTH-1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  PC_W  PC of the retiring instruction.
- ret_inst  in  3  instruction class code (INST_* constants).
- ret_alu  in  3  ALU control of the retiring instruction.
- arm  in  1  one-cycle pulse: clear the buffer and start capture.
- trig_inst  in  3  instruction class that fires the trigger.
- trig_en  in  1  trigger enable; 0 means capture never stops.
- rd_ready  in  1  consumer accepts the current read entry.
- rd_valid  out  1  read entry present.
- rd_pc  out  PC_W  PC of the read entry.
- rd_inst_text  out  48  6-char ASCII class name.
- rd_alu_text  out  32  4-char ASCII ALU op name.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- count  out  $clog2(DEPTH)+1  valid entries held.

## Operation
- FSM states: IDLE, ARMED, POST, DONE.
- IDLE: ignore retirements. On arm: wr_ptr=0, count=0, go to ARMED.
- ARMED: each ret_valid writes {pc,inst,alu} at wr_ptr, wr_ptr+=1 mod DEPTH, count=min(count+1,DEPTH). When trig_en and ret_inst==trig_inst on a valid retirement, write that entry and then go to POST with post_cnt=POST_TRIG. If POST_TRIG==0, go straight to DONE.
- POST: each write decrements post_cnt. The write that takes post_cnt to 0 moves the FSM to DONE.
- DONE: capture stops. rd_ptr = (wr_ptr - count) mod DEPTH, the oldest entry. rd_valid = (count!=0). On rd_valid&&rd_ready: rd_ptr+=1 and count-=1. When count reaches 0, rd_valid drops and the FSM stays in DONE.
- arm in any state restarts as from IDLE. arm wins over a simultaneous write, trigger or read; that cycle's retirement is discarded.
- Full buffer in ARMED/POST: overwrite the oldest entry; count stays at DEPTH.
- Text decode, inst: ALUI "ALUI  ", ALUR "ALUR  ", SHRO "SHRO  ", LOAD "LOAD  ", STORE "STORE ", BRANCH "BRANCH", MUL "MUL   ", other "UNDEF ".
- Text decode, alu: 000 "MOVA", 001 "MOVB", 010 "AND ", 011 "OR  ", 10x "ADD ", 11x "SUB ".
- Decode is applied to stored codes. Only raw codes are stored.

## Timing
- Reset (rst_n low at a clk edge): state=IDLE, count=0, rd_valid=0, rd_pc=0, rd_inst_text="UNDEF ", rd_alu_text="MOVA". Reset mid-capture or mid-drain discards all entries.
- Write latency: an entry retired at edge N is counted at edge N+1.
- Trigger: the transition to POST/DONE is visible on state one cycle after the triggering retirement.
- Read: rd_* outputs are registered. After entry to DONE with count>0, rd_valid rises within 2 cycles. After an accept, the next entry is presented the following cycle, giving sustained 1 entry/cycle. rd_* stay stable while rd_valid&&!rd_ready.
- Storage is synchronous-read memory with DEPTH x (PC_W+6) bits.

## Structure
- Shared package/header: INST_* class codes, ALU control codes, state encodings, and the ASCII text constants.
- Sub-module debug_text: combinational decode of {inst, alu} to {48-bit, 32-bit} text. Use one instance on the read path.
- debug_trace holds the FSM, pointers, counters and storage.

## Test plan
- Reset then idle. Drive 5 retirements with no arm -> count=0, state=IDLE, rd_valid=0, rd_inst_text="UNDEF ".
- DEPTH=16, POST_TRIG=4, trigger=BRANCH. Arm, retire 3 ALUR (pc 0x10,0x14,0x18), 1 BRANCH (0x1C), 4 LOAD -> state=DONE, count=8. Reads return PCs 0x10..0x2C in order with texts "ALUR  ","BRANCH","LOAD  ". Stray retirements after DONE are ignored.
- Wrap: arm, retire 20 ALUI with pc 0..19 and no trigger until the 21st retirement (BRANCH, pc 20), POST_TRIG=0 -> count=16. The first read is pc 5 and the last is pc 20.
- Backpressure: toggle rd_ready 1/0 during the drain -> no entry is dropped or duplicated, and outputs hold while stalled.
- alu_ctl 101 and 111 read back as "ADD " and "SUB ". Unknown inst code 111 reads back as "UNDEF ".
- Re-arm mid-drain and assert rst_n low mid-POST -> count=0 and state=ARMED/IDLE respectively on the next cycle.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: shared constants for the simplecore instruction trace.
//   - INST_* : 3-bit instruction class codes as seen at writeback
//   - ALU_*  : 3-bit ALU control codes (10x = ADD, 11x = SUB)
//   - trace_state_t : recorder FSM encoding, exported on the state port
//   - TXT_*  : fixed-width ASCII mnemonics used by debug_text
package debug_trace_pkg;

  localparam logic [2:0] INST_ALUI   = 3'd0;
  localparam logic [2:0] INST_ALUR   = 3'd1;
  localparam logic [2:0] INST_SHRO   = 3'd2;
  localparam logic [2:0] INST_LOAD   = 3'd3;
  localparam logic [2:0] INST_STORE  = 3'd4;
  localparam logic [2:0] INST_BRANCH = 3'd5;
  localparam logic [2:0] INST_MUL    = 3'd6;
  localparam logic [2:0] INST_UNDEF  = 3'd7;

  localparam logic [2:0] ALU_MOVA  = 3'b000;
  localparam logic [2:0] ALU_MOVB  = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_ADD_X = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam logic [47:0] TXT_ALUI   = "ALUI  ";
  localparam logic [47:0] TXT_ALUR   = "ALUR  ";
  localparam logic [47:0] TXT_SHRO   = "SHRO  ";
  localparam logic [47:0] TXT_LOAD   = "LOAD  ";
  localparam logic [47:0] TXT_STORE  = "STORE ";
  localparam logic [47:0] TXT_BRANCH = "BRANCH";
  localparam logic [47:0] TXT_MUL    = "MUL   ";
  localparam logic [47:0] TXT_UNDEF  = "UNDEF ";

  localparam logic [31:0] TXT_MOVA = "MOVA";
  localparam logic [31:0] TXT_MOVB = "MOVB";
  localparam logic [31:0] TXT_AND  = "AND ";
  localparam logic [31:0] TXT_OR   = "OR  ";
  localparam logic [31:0] TXT_ADD  = "ADD ";
  localparam logic [31:0] TXT_SUB  = "SUB ";

endpackage

// File: rtl/debug_trace_text.sv
// debug_text: combinational decode of stored trace codes to ASCII.
//   i_inst      : instruction class code
//   i_alu       : ALU control code
//   o_inst_text : 6-char class mnemonic
//   o_alu_text  : 4-char ALU op mnemonic
module debug_text
  import debug_trace_pkg::*;
(
  input  logic [2:0]  i_inst,
  input  logic [2:0]  i_alu,
  output logic [47:0] o_inst_text,
  output logic [31:0] o_alu_text
);

  always_comb begin
    o_inst_text = TXT_UNDEF;
    case (i_inst)
      INST_ALUI:   o_inst_text = TXT_ALUI;
      INST_ALUR:   o_inst_text = TXT_ALUR;
      INST_SHRO:   o_inst_text = TXT_SHRO;
      INST_LOAD:   o_inst_text = TXT_LOAD;
      INST_STORE:  o_inst_text = TXT_STORE;
      INST_BRANCH: o_inst_text = TXT_BRANCH;
      INST_MUL:    o_inst_text = TXT_MUL;
      default:     o_inst_text = TXT_UNDEF;
    endcase

    o_alu_text = TXT_MOVA;
    case (i_alu)
      ALU_MOVA:           o_alu_text = TXT_MOVA;
      ALU_MOVB:           o_alu_text = TXT_MOVB;
      ALU_AND:            o_alu_text = TXT_AND;
      ALU_OR:             o_alu_text = TXT_OR;
      ALU_ADD, ALU_ADD_X: o_alu_text = TXT_ADD;
      default:            o_alu_text = TXT_SUB;
    endcase
  end

endmodule

// File: rtl/debug_trace.sv
// debug_trace: circular retirement trace with trigger + post-trigger window,
// drained oldest-first through a valid/ready port once frozen.
//   clk, rst_n                   : clock, synchronous active-low reset
//   ret_valid/pc/inst/alu        : retirement observation (never stalled)
//   arm                          : clear buffer and start capture
//   trig_inst, trig_en           : trigger class and enable
//   rd_ready / rd_valid, rd_pc   : read handshake and entry PC
//   rd_inst_text, rd_alu_text    : ASCII decode of the read entry
//   state, count                 : FSM state and entries held
module debug_trace
  import debug_trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ret_valid,
  input  logic [PC_W-1:0]          ret_pc,
  input  logic [2:0]               ret_inst,
  input  logic [2:0]               ret_alu,
  input  logic                     arm,
  input  logic [2:0]               trig_inst,
  input  logic                     trig_en,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [47:0]              rd_inst_text,
  output logic [31:0]              rd_alu_text,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + 6;

  trace_state_t    r_state;
  trace_state_t    w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_post_cnt;
  logic [CW-1:0]   r_count;
  logic [EW-1:0]   r_mem [DEPTH];
  logic            r_rd_valid;
  logic [PC_W-1:0] r_rd_pc;
  logic [2:0]      r_rd_inst;
  logic [2:0]      r_rd_alu;

  logic            w_write;
  logic            w_trig_hit;
  logic            w_accept;
  logic            w_fetch;
  logic [AW-1:0]   w_rd_ptr;
  logic [AW-1:0]   w_rd_addr;
  logic [EW-1:0]   w_rd_q;

  assign w_write    = ret_valid && !arm && (r_state == ST_ARMED || r_state == ST_POST);
  assign w_trig_hit = trig_en && (ret_inst == trig_inst);
  assign w_accept   = r_rd_valid && rd_ready;

  // Once frozen, wr_ptr is fixed and count shrinks as entries leave, so the
  // oldest entry is always wr_ptr - count; no separate read pointer needed.
  assign w_rd_ptr  = r_wr_ptr - r_count[AW-1:0];
  assign w_rd_addr = w_accept ? w_rd_ptr + AW'(1) : w_rd_ptr;
  assign w_rd_q    = r_mem[w_rd_addr];

  // Load the output register on the first cycle in DONE, or on an accept
  // when more entries remain (back-to-back, 1 entry/cycle).
  assign w_fetch = (r_state == ST_DONE) &&
                   ((!r_rd_valid && r_count != '0) || (w_accept && r_count != CW'(1)));

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_ARMED: if (ret_valid && w_trig_hit)
                    w_state_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (ret_valid && r_post_cnt == AW'(1))
                    w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {ret_pc, ret_inst, ret_alu};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_inst  <= INST_UNDEF;
      r_rd_alu   <= ALU_MOVA;
    end else if (arm) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
        if (r_state == ST_ARMED && w_trig_hit) r_post_cnt <= AW'(POST_TRIG);
        else if (r_state == ST_POST)           r_post_cnt <= r_post_cnt - AW'(1);
      end
      if (r_state == ST_DONE) begin
        if (w_accept) r_count <= r_count - CW'(1);
        if (w_fetch) begin
          r_rd_valid <= 1'b1;
          r_rd_pc    <= w_rd_q[EW-1:6];
          r_rd_inst  <= w_rd_q[5:3];
          r_rd_alu   <= w_rd_q[2:0];
        end else if (w_accept) begin
          r_rd_valid <= 1'b0;
        end
      end
    end
  end

  debug_text u_text (
    .i_inst      (r_rd_inst),
    .i_alu       (r_rd_alu),
    .o_inst_text (rd_inst_text),
    .o_alu_text  (rd_alu_text)
  );

  assign rd_valid = r_rd_valid;
  assign rd_pc    = r_rd_pc;
  assign state    = r_state;
  assign count    = r_count;

endmodule

// File: tb/tb_debug_trace.sv
module tb_debug_trace;
  import debug_trace_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ret_valid, arm, trig_en, rd_ready;
  logic [31:0] ret_pc;
  logic [2:0]  ret_inst, ret_alu, trig_inst;

  // index 0: POST_TRIG=4, index 1: POST_TRIG=0
  logic [1:0]       rdv;
  logic [1:0][31:0] rdpc;
  logic [1:0][47:0] rdit;
  logic [1:0][31:0] rdat;
  logic [1:0][1:0]  st;
  logic [1:0][4:0]  cnt;

  debug_trace #(.DEPTH(16), .PC_W(32), .POST_TRIG(4)) u_dut_p4 (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_inst(ret_inst), .ret_alu(ret_alu), .arm(arm), .trig_inst(trig_inst),
    .trig_en(trig_en), .rd_ready(rd_ready), .rd_valid(rdv[0]), .rd_pc(rdpc[0]),
    .rd_inst_text(rdit[0]), .rd_alu_text(rdat[0]), .state(st[0]), .count(cnt[0])
  );

  debug_trace #(.DEPTH(16), .PC_W(32), .POST_TRIG(0)) u_dut_p0 (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_inst(ret_inst), .ret_alu(ret_alu), .arm(arm), .trig_inst(trig_inst),
    .trig_en(trig_en), .rd_ready(rd_ready), .rd_valid(rdv[1]), .rd_pc(rdpc[1]),
    .rd_inst_text(rdit[1]), .rd_alu_text(rdat[1]), .state(st[1]), .count(cnt[1])
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [47:0] it;
    logic [31:0] at;
  } entry_t;

  typedef struct {
    logic [2:0]  inst;
    logic [2:0]  alu;
    logic [47:0] it;
    logic [31:0] at;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  entry_t q0[$];
  entry_t q1[$];
  int     mstate[2];
  int     mpost[2];
  int     ptrig[2] = '{4, 0};
  logic   hold_chk_en = 1'b0;
  logic   prev_stall[2];
  logic [31:0] prev_pc[2];
  logic [47:0] prev_it[2];
  logic [31:0] prev_at[2];

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input int new_state);
    for (int d = 0; d < 2; d++) mstate[d] = new_state;
    q0.delete();
    q1.delete();
  endtask

  task automatic model_write(input entry_t e, input logic [2:0] inst);
    for (int d = 0; d < 2; d++) begin
      if (mstate[d] == 1 || mstate[d] == 2) begin
        if (d == 0) begin q0.push_back(e); if (q0.size() > 16) void'(q0.pop_front()); end
        else        begin q1.push_back(e); if (q1.size() > 16) void'(q1.pop_front()); end
        if (mstate[d] == 1) begin
          if (trig_en && inst == trig_inst) begin
            if (ptrig[d] == 0) mstate[d] = 3;
            else begin mstate[d] = 2; mpost[d] = ptrig[d]; end
          end
        end else begin
          mpost[d]--;
          if (mpost[d] == 0) mstate[d] = 3;
        end
      end
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic [2:0] inst, input logic [2:0] alu,
                        input logic [47:0] it, input logic [31:0] at);
    entry_t e;
    ret_valid = 1'b1; ret_pc = pc; ret_inst = inst; ret_alu = alu;
    e.pc = pc; e.it = it; e.at = at;
    model_write(e, inst);
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    model_clear(1);
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input int mode, input int budget);
    int n = 0;
    hold_chk_en = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    rd_ready = 1'b0;
    hold_chk_en = 1'b0;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d entries left after %0d cycles, expected 0/0",
               q0.size(), q1.size(), budget);
    end
    for (int d = 0; d < 2; d++) begin
      chk(d, "drain_count", 64'(cnt[d]), 64'(0));
      chk(d, "drain_valid", 64'(rdv[d]), 64'(0));
    end
  endtask

  // Scoreboard: every accepted read is matched against the model's oldest entry.
  always @(negedge clk) begin
    entry_t e;
    for (int d = 0; d < 2; d++) begin
      if (hold_chk_en && prev_stall[d]) begin
        chk(d, "hold_valid", 64'(rdv[d]), 64'(1));
        chk(d, "hold_pc", 64'(rdpc[d]), 64'(prev_pc[d]));
        chk(d, "hold_inst", 64'(rdit[d]), 64'(prev_it[d]));
        chk(d, "hold_alu", 64'(rdat[d]), 64'(prev_at[d]));
      end
      if (rdv[d] && rd_ready) begin
        if (qsize(d) == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read dut%0d: got pc %0h, expected no entry", d, rdpc[d]);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk(d, "rd_pc", 64'(rdpc[d]), 64'(e.pc));
          chk(d, "rd_inst_text", 64'(rdit[d]), 64'(e.it));
          chk(d, "rd_alu_text", 64'(rdat[d]), 64'(e.at));
        end
      end
      prev_stall[d] = rdv[d] && !rd_ready;
      prev_pc[d] = rdpc[d];
      prev_it[d] = rdit[d];
      prev_at[d] = rdat[d];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{INST_ALUI,   3'b000, "ALUI  ", "MOVA"};
    tbl[1] = '{INST_ALUR,   3'b001, "ALUR  ", "MOVB"};
    tbl[2] = '{INST_SHRO,   3'b010, "SHRO  ", "AND "};
    tbl[3] = '{INST_LOAD,   3'b011, "LOAD  ", "OR  "};
    tbl[4] = '{INST_STORE,  3'b100, "STORE ", "ADD "};
    tbl[5] = '{INST_UNDEF,  3'b101, "UNDEF ", "ADD "};
    tbl[6] = '{INST_BRANCH, 3'b110, "BRANCH", "SUB "};
    tbl[7] = '{INST_MUL,    3'b111, "MUL   ", "SUB "};
    tbl[8] = '{INST_ALUR,   3'b101, "ALUR  ", "ADD "};
    tbl[9] = '{INST_LOAD,   3'b111, "LOAD  ", "SUB "};

    rst_n = 1'b0; ret_valid = 1'b0; arm = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
    ret_pc = '0; ret_inst = '0; ret_alu = '0; trig_inst = '0;
    model_clear(0);
    for (int d = 0; d < 2; d++) prev_stall[d] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_state", 64'(st[d]), 64'(0));
      chk(d, "rst_count", 64'(cnt[d]), 64'(0));
      chk(d, "rst_valid", 64'(rdv[d]), 64'(0));
      chk(d, "rst_pc", 64'(rdpc[d]), 64'(0));
      chk(d, "rst_inst_text", 64'(rdit[d]), 64'("UNDEF "));
      chk(d, "rst_alu_text", 64'(rdat[d]), 64'("MOVA"));
    end
    rst_n = 1'b1;
    tick();

    // Retirements without arm are ignored
    for (int i = 0; i < 5; i++) retire(32'h40 + 32'(i) * 4, INST_ALUR, 3'b001, "ALUR  ", "MOVB");
    for (int d = 0; d < 2; d++) begin
      chk(d, "idle_state", 64'(st[d]), 64'(0));
      chk(d, "idle_count", 64'(cnt[d]), 64'(0));
      chk(d, "idle_valid", 64'(rdv[d]), 64'(0));
      chk(d, "idle_inst_text", 64'(rdit[d]), 64'("UNDEF "));
    end

    // Basic capture, trigger on BRANCH
    trig_en = 1'b1;
    trig_inst = INST_BRANCH;
    do_arm();
    for (int d = 0; d < 2; d++) chk(d, "arm_state", 64'(st[d]), 64'(1));
    retire(32'h10, INST_ALUR, 3'b101, "ALUR  ", "ADD ");
    for (int d = 0; d < 2; d++) chk(d, "first_count", 64'(cnt[d]), 64'(1));
    retire(32'h14, INST_ALUR, 3'b100, "ALUR  ", "ADD ");
    retire(32'h18, INST_ALUR, 3'b100, "ALUR  ", "ADD ");
    retire(32'h1C, INST_BRANCH, 3'b111, "BRANCH", "SUB ");
    chk(0, "trig_state", 64'(st[0]), 64'(2));
    chk(1, "trig_state", 64'(st[1]), 64'(3));
    for (int i = 0; i < 4; i++) retire(32'h20 + 32'(i) * 4, INST_LOAD, 3'b000, "LOAD  ", "MOVA");
    chk(0, "done_state", 64'(st[0]), 64'(3));
    chk(0, "done_count", 64'(cnt[0]), 64'(8));
    chk(1, "done_count", 64'(cnt[1]), 64'(4));
    retire(32'h80, INST_ALUR, 3'b000, "ALUR  ", "MOVA");
    retire(32'h84, INST_BRANCH, 3'b000, "BRANCH", "MOVA");
    chk(0, "stray_count", 64'(cnt[0]), 64'(8));
    chk(1, "stray_count", 64'(cnt[1]), 64'(4));
    drain(0, 12);

    // Wrap-around: 20 ALUI then BRANCH, 4 LOAD
    do_arm();
    for (int i = 0; i < 20; i++) retire(32'(i), INST_ALUI, 3'b010, "ALUI  ", "AND ");
    for (int d = 0; d < 2; d++) begin
      chk(d, "wrap_full_count", 64'(cnt[d]), 64'(16));
      chk(d, "wrap_state", 64'(st[d]), 64'(1));
    end
    retire(32'd20, INST_BRANCH, 3'b011, "BRANCH", "OR  ");
    chk(1, "wrap_p0_state", 64'(st[1]), 64'(3));
    for (int i = 21; i < 25; i++) retire(32'(i), INST_LOAD, 3'b001, "LOAD  ", "MOVB");
    chk(0, "wrap_p4_state", 64'(st[0]), 64'(3));
    for (int d = 0; d < 2; d++) chk(d, "wrap_count", 64'(cnt[d]), 64'(16));
    drain(1, 80);

    // Decode table, trigger on the unknown class code
    trig_inst = INST_UNDEF;
    do_arm();
    for (int i = 0; i < 10; i++)
      retire(32'h200 + 32'(i) * 4, tbl[i].inst, tbl[i].alu, tbl[i].it, tbl[i].at);
    for (int d = 0; d < 2; d++) chk(d, "tbl_state", 64'(st[d]), 64'(3));
    chk(0, "tbl_count", 64'(cnt[0]), 64'(10));
    chk(1, "tbl_count", 64'(cnt[1]), 64'(6));
    drain(2, 200);

    // Re-arm in the middle of a drain; the simultaneous retirement is dropped
    trig_inst = INST_BRANCH;
    do_arm();
    retire(32'h300, INST_BRANCH, 3'b000, "BRANCH", "MOVA");
    for (int i = 0; i < 4; i++) retire(32'h304 + 32'(i) * 4, INST_LOAD, 3'b000, "LOAD  ", "MOVA");
    tick();
    chk(0, "valid_rise", 64'(rdv[0]), 64'(1));
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    chk(0, "partial_count", 64'(cnt[0]), 64'(3));
    chk(1, "partial_count", 64'(cnt[1]), 64'(0));
    arm = 1'b1; ret_valid = 1'b1; ret_pc = 32'h3F0; ret_inst = INST_ALUI; ret_alu = 3'b000;
    model_clear(1);
    tick();
    arm = 1'b0; ret_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rearm_count", 64'(cnt[d]), 64'(0));
      chk(d, "rearm_state", 64'(st[d]), 64'(1));
      chk(d, "rearm_valid", 64'(rdv[d]), 64'(0));
    end
    retire(32'h400, INST_ALUI, 3'b000, "ALUI  ", "MOVA");
    for (int d = 0; d < 2; d++) chk(d, "rearm_write", 64'(cnt[d]), 64'(1));

    // Reset in the middle of the post-trigger window
    do_arm();
    retire(32'h500, INST_BRANCH, 3'b000, "BRANCH", "MOVA");
    retire(32'h504, INST_LOAD, 3'b000, "LOAD  ", "MOVA");
    chk(0, "post_state", 64'(st[0]), 64'(2));
    rst_n = 1'b0;
    model_clear(0);
    tick();
    for (int d = 0; d < 2; d++) begin
      chk(d, "midrst_state", 64'(st[d]), 64'(0));
      chk(d, "midrst_count", 64'(cnt[d]), 64'(0));
      chk(d, "midrst_valid", 64'(rdv[d]), 64'(0));
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
